// File: rtl/dilithium_input_framer_if.sv
// Host-side and core-side word handshakes of the Dilithium input framer.
// Latency: none (signal bundle only).
// Backpressure: ready_i throttles the host, core_ready throttles the framer.
interface dilithium_input_framer_if;
   logic        valid_i;
   logic        ready_i;
   logic [63:0] data_i;
   logic        last_i;
   logic        core_valid;
   logic        core_ready;
   logic [63:0] core_data;

   // Environment view: drives host words and core acceptance
   modport master (
      output valid_i, data_i, last_i, core_ready,
      input  ready_i, core_valid, core_data
   );

   // Framer view: consumes host words, produces core words
   modport slave (
      input  valid_i, data_i, last_i, core_ready,
      output ready_i, core_valid, core_data
   );
endinterface

// File: rtl/dilithium_input_framer.sv
// Frames host words for the Dilithium core and checks host last_i against the expected length.
// Latency: 1 cycle host accept to core_data (registered head of a 2-entry skid buffer).
// Backpressure: registered ready_i = skid buffer not full; core_valid/core_data hold until core_ready.
module dilithium_input_framer #(
   parameter int MAX_MSG_WORDS = 16384,
   parameter int CTR_W         = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [1:0]               mode,
   input  logic [2:0]               sec_lvl,
   dilithium_input_framer_if.slave  bus,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic [CTR_W-1:0]         word_ctr
);
   localparam int MW    = $clog2(MAX_MSG_WORDS + 1);
   localparam int REM_W = (MW > 10) ? MW : 10;

   typedef enum logic [2:0] {S_IDLE, S_FIXED, S_LEN, S_MSG, S_DRAIN, S_ERR} state_t;

   state_t             state_q, state_d;
   logic [REM_W-1:0]   rem_q, rem_d;     // words still expected in the current phase
   logic               kg_q, kg_d;       // keygen frame: no length word, no message
   logic               fin_q, fin_d;     // all expected words taken, waiting for the buffer to drain
   logic               ready_q, ready_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic [CTR_W-1:0]   ctr_q, ctr_d;
   logic [1:0]         cnt_q, cnt_d;     // skid buffer occupancy
   logic [63:0]        buf0_q, buf0_d;   // head entry, drives core_data
   logic [63:0]        buf1_q, buf1_d;

   logic               acc, pop, push, drained, cfg_ok;
   logic [9:0]         f_len;
   logic [61:0]        m_words;

   assign acc     = bus.valid_i && ready_q;
   assign pop     = (cnt_q != 2'd0) && bus.core_ready;
   // Buffer is empty after this cycle, valid whenever nothing is pushed
   assign drained = (cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop);
   assign m_words = {1'b0, bus.data_i[63:3]} + 62'(bus.data_i[2:0] != 3'd0);

   // Fixed-part length and legality of the requested mode / security level
   always_comb begin
      f_len  = 10'd0;
      cfg_ok = (mode != 2'd3) && ((sec_lvl == 3'd2) || (sec_lvl == 3'd3) || (sec_lvl == 3'd5));
      case (mode)
         2'd0: f_len = 10'd4;
         2'd1: f_len = (sec_lvl == 3'd2) ? 10'd318 : (sec_lvl == 3'd3) ? 10'd502 : 10'd610;
         2'd2: f_len = (sec_lvl == 3'd2) ? 10'd467 : (sec_lvl == 3'd3) ? 10'd656 : 10'd899;
         default: f_len = 10'd0;
      endcase
   end

   // Frame sequencing: phase counting, last_i checking, error handling
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      kg_d    = kg_q;
      fin_d   = fin_q;
      err_d   = err_q;
      ctr_d   = ctr_q;
      done_d  = 1'b0;
      push    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (cfg_ok) begin
                  err_d   = 1'b0;
                  ctr_d   = '0;
                  rem_d   = REM_W'(f_len);
                  kg_d    = (mode == 2'd0);
                  fin_d   = 1'b0;
                  state_d = S_FIXED;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_FIXED, S_MSG, S_LEN: begin
            if (fin_q) begin
               if (drained) begin
                  fin_d   = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end else if (acc) begin
               if (ctr_q != '1) ctr_d = ctr_q + 1'b1;
               if (state_q == S_LEN) begin
                  if (m_words > 62'(MAX_MSG_WORDS)) begin
                     // Oversized message: the length word is swallowed, not forwarded
                     err_d = 1'b1;
                     if (!bus.last_i)  state_d = S_DRAIN;
                     else if (drained) state_d = S_IDLE;
                     else              state_d = S_ERR;
                  end else begin
                     push = 1'b1;
                     if (m_words == '0) begin
                        if (bus.last_i) fin_d = 1'b1;
                        else begin err_d = 1'b1; state_d = S_DRAIN; end
                     end else if (bus.last_i) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                     end else begin
                        rem_d   = m_words[REM_W-1:0];
                        state_d = S_MSG;
                     end
                  end
               end else begin
                  push  = 1'b1;
                  rem_d = rem_q - 1'b1;
                  if ((rem_q == REM_W'(1)) && ((state_q == S_MSG) || kg_q)) begin
                     if (bus.last_i) fin_d = 1'b1;
                     else begin err_d = 1'b1; state_d = S_DRAIN; end
                  end else if (bus.last_i) begin
                     err_d   = 1'b1;
                     state_d = S_ERR;
                  end else if (rem_q == REM_W'(1)) begin
                     state_d = S_LEN;
                  end
               end
            end
         end
         S_DRAIN: begin
            if (acc && bus.last_i) state_d = drained ? S_IDLE : S_ERR;
         end
         S_ERR: begin
            if (drained) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // Two-entry skid buffer: head feeds the core, second entry absorbs a stalled cycle
   always_comb begin
      buf0_d = buf0_q;
      buf1_d = buf1_q;
      cnt_d  = cnt_q;
      case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) buf0_d = bus.data_i;
            else               buf1_d = bus.data_i;
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            buf0_d = buf1_q;
            cnt_d  = cnt_q - 2'd1;
         end
         2'b11: begin
            if (cnt_q == 2'd1) begin
               buf0_d = bus.data_i;
            end else begin
               buf0_d = buf1_q;
               buf1_d = bus.data_i;
            end
         end
         default: ;
      endcase
   end

   // Host ready for next cycle: room in the buffer while expecting words, always while draining
   always_comb begin
      ready_d = ((state_d == S_FIXED) || (state_d == S_LEN) || (state_d == S_MSG))
                && !fin_d && (cnt_d != 2'd2);
      if (state_d == S_DRAIN) ready_d = 1'b1;
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         kg_q    <= 1'b0;
         fin_q   <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         ctr_q   <= '0;
         cnt_q   <= 2'd0;
         buf0_q  <= '0;
         buf1_q  <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         kg_q    <= kg_d;
         fin_q   <= fin_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         ctr_q   <= ctr_d;
         cnt_q   <= cnt_d;
         buf0_q  <= buf0_d;
         buf1_q  <= buf1_d;
      end
   end

   assign bus.ready_i    = ready_q;
   assign bus.core_valid = (cnt_q != 2'd0);
   assign bus.core_data  = buf0_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign err            = err_q;
   assign word_ctr       = ctr_q;
endmodule
